// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the CORDIC DDS: steps the phase increment from a
// start to an end value, retuning with SET and holding each step for a dwell time.
module dds_sweep_ctrl #(
  parameter int ADDRESS_WIDTH    = 8,
  parameter int DWELL_WIDTH      = 16,
  parameter int VALUETABEL_DELAY = 10
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [ADDRESS_WIDTH-1:0] step_start,
  input  logic [ADDRESS_WIDTH-1:0] step_end,
  input  logic [ADDRESS_WIDTH-1:0] step_inc,
  input  logic [DWELL_WIDTH-1:0]   dwell_in,
  output logic                     SET,
  output logic [ADDRESS_WIDTH-1:0] step_out,
  output logic                     value_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int SETTLE_W = $clog2(VALUETABEL_DELAY + 1);
  localparam int CNT_W    = (DWELL_WIDTH > SETTLE_W) ? DWELL_WIDTH : SETTLE_W;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(VALUETABEL_DELAY - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DWELL, DONE} state_t;

  state_t                   state_reg;
  logic [ADDRESS_WIDTH-1:0] start_reg;
  logic [ADDRESS_WIDTH-1:0] end_reg;
  logic [ADDRESS_WIDTH-1:0] inc_reg;
  logic [DWELL_WIDTH-1:0]   dwell_reg;
  logic                     loop_reg;
  logic [CNT_W-1:0]         cnt_reg;

  logic [ADDRESS_WIDTH:0]   step_sum;
  logic [ADDRESS_WIDTH-1:0] step_next;
  logic [CNT_W-1:0]         dwell_last;

  // step_out doubles as the current-step register; the extra sum bit catches wrap.
  assign step_sum   = {1'b0, step_out} + {1'b0, inc_reg};
  assign dwell_last = CNT_W'(dwell_reg) - CNT_W'(1);

  always_comb begin
    step_next = step_sum[ADDRESS_WIDTH-1:0];
    if (step_sum[ADDRESS_WIDTH] || (step_sum[ADDRESS_WIDTH-1:0] > end_reg))
      step_next = end_reg;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= IDLE;
      start_reg   <= '0;
      end_reg     <= '0;
      inc_reg     <= '0;
      dwell_reg   <= '0;
      loop_reg    <= 1'b0;
      cnt_reg     <= '0;
      SET         <= 1'b0;
      step_out    <= '0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (stop && (state_reg != IDLE)) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      SET         <= 1'b0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            start_reg <= step_start;
            end_reg   <= step_end;
            inc_reg   <= (step_inc == '0) ? ADDRESS_WIDTH'(1) : step_inc;
            dwell_reg <= (dwell_in == '0) ? DWELL_WIDTH'(1) : dwell_in;
            loop_reg  <= loop;
            step_out  <= step_start;
            SET       <= 1'b1;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          SET       <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= SETTLE;
        end
        SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg     <= '0;
            value_valid <= 1'b1;
            state_reg   <= DWELL;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DWELL: begin
          if (cnt_reg == dwell_last) begin
            cnt_reg     <= '0;
            value_valid <= 1'b0;
            // A reversed range lands here on its first step, giving a single-step sweep.
            if (step_out >= end_reg) begin
              done      <= 1'b1;
              busy      <= loop_reg;
              state_reg <= DONE;
            end else begin
              step_out  <= step_next;
              SET       <= 1'b1;
              state_reg <= LOAD;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
          if (loop_reg) begin
            step_out  <= start_reg;
            SET       <= 1'b1;
            state_reg <= LOAD;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a sweep model queues expected SET/done
// events; a monitor pops and compares them as the DUT produces them.
module tb_dds_sweep_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int VD = 10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] step_start = '0;
  logic [AW-1:0] step_end = '0;
  logic [AW-1:0] step_inc = '0;
  logic [DW-1:0] dwell_in = '0;
  logic          SET;
  logic [AW-1:0] step_out;
  logic          value_valid;
  logic          busy;
  logic          done;

  dds_sweep_ctrl #(.ADDRESS_WIDTH(AW), .DWELL_WIDTH(DW), .VALUETABEL_DELAY(VD)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .loop(loop),
    .step_start(step_start), .step_end(step_end), .step_inc(step_inc),
    .dwell_in(dwell_in), .SET(SET), .step_out(step_out),
    .value_valid(value_valid), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    bit is_done;
    int step;
    int at;
    int vcnt;
  } ev_t;

  ev_t exp_q[$];
  ev_t mq[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference sweep: list of SET/done events with the valid cycles preceding each.
  function automatic void build(input int c, input int s0, input int e0, input int inc0,
                                input int dw0, input bit lp, input int horizon);
    int inc, dw, t, s, vc;
    ev_t ev;
    inc = (inc0 == 0) ? 1 : inc0;
    dw  = (dw0 == 0) ? 1 : dw0;
    t = c + 1;
    s = s0;
    vc = 0;
    mq.delete();
    while (t <= horizon) begin
      ev.is_done = 1'b0; ev.step = s; ev.at = t; ev.vcnt = vc;
      mq.push_back(ev);
      vc = dw;
      if (s >= e0) begin
        ev.is_done = 1'b1; ev.step = 0; ev.at = t + 1 + VD + dw; ev.vcnt = dw;
        mq.push_back(ev);
        if (!lp) break;
        s = s0;
        t = ev.at + 1;
        vc = 0;
      end else begin
        s = (s + inc > e0) ? e0 : s + inc;
        t = t + 1 + VD + dw;
      end
    end
  endfunction

  // Monitor
  ev_t mon_e;
  int  vcnt = 0;
  int  last_step = 0;
  bit  busy_prev = 1'b0;
  int  busy_fall_at = -1;
  int  last_done_at = -1;

  always @(negedge CLK) begin
    if (SET || done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_event: got SET=%0d done=%0d step=%0d, expected none (cycle %0d)",
                 SET, done, step_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", int'(done), int'(mon_e.is_done));
        check("event_cycle", cyc, mon_e.at);
        check("valid_cycles", vcnt, mon_e.vcnt);
        if (SET) check("set_step", int'(step_out), mon_e.step);
      end
      vcnt = 0;
      if (SET) last_step = int'(step_out);
    end else if (busy) begin
      check("step_hold", int'(step_out), last_step);
    end
    if (value_valid) vcnt++;
    if (!busy && !done) vcnt = 0;
    if (busy_prev && !busy) busy_fall_at = cyc;
    busy_prev = busy;
    if (done) last_done_at = cyc;
  end

  task automatic scramble_cfg();
    step_start = AW'($urandom);
    step_end   = AW'($urandom);
    step_inc   = AW'($urandom);
    dwell_in   = DW'($urandom);
    loop       = 1'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_SET"}, int'(SET), 0);
    check({tag, "_step_out"}, int'(step_out), 0);
    check({tag, "_valid"}, int'(value_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // One sweep; stop_after >= 0 asserts stop that many cycles after the start cycle.
  task automatic run(input int s0, input int e0, input int inc0, input int dw0,
                     input bit lp, input int stop_after, output int c_out);
    int c, sc, budget, drops, stop_step;
    @(negedge CLK);
    c = cyc;
    c_out = c;
    step_start = AW'(s0);
    step_end   = AW'(e0);
    step_inc   = AW'(inc0);
    dwell_in   = DW'(dw0);
    loop       = lp;
    start      = 1'b1;
    sc = (stop_after < 0) ? c + 100000 : c + stop_after;
    build(c, s0, e0, inc0, dw0, lp, sc);
    stop_step = s0;
    foreach (mq[i]) begin
      if (mq[i].at <= sc) begin
        exp_q.push_back(mq[i]);
        if (!mq[i].is_done) stop_step = mq[i].step;
      end
    end
    @(negedge CLK);
    start = 1'b0;
    scramble_cfg();
    repeat (3) @(negedge CLK);
    // A start mid-sweep must be ignored.
    start = 1'b1;
    scramble_cfg();
    @(negedge CLK);
    start = 1'b0;
    if (stop_after >= 0) begin
      drops = 0;
      while (cyc < sc) begin
        if (!busy) drops++;
        @(negedge CLK);
      end
      if (lp) check("loop_busy_drops", drops, 0);
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      check("stop_busy", int'(busy), 0);
      check("stop_valid", int'(value_valid), 0);
      check("stop_SET", int'(SET), 0);
      check("stop_done", int'(done), 0);
      check("stop_step_hold", int'(step_out), stop_step);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 5000) begin
      @(negedge CLK);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL sweep_timeout: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge CLK);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s0, e0, inc0, dw0;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check_outputs_zero("reset");
    @(posedge CLK);
    #2 RESET = 1'b1;

    // Basic ramp: SET at +1,+16,+31, done at +46, busy low from +46.
    run(1, 3, 1, 4, 1'b0, -1, c);
    check("basic_done_cycle", last_done_at - c, 46);
    check("basic_busy_fall", busy_fall_at - c, 46);

    run(250, 255, 10, 3, 1'b0, -1, c);   // overflow clamp
    run(9, 5, 1, 2, 1'b0, -1, c);        // reversed range
    run(0, 2, 0, 0, 1'b0, -1, c);        // zero inc and dwell
    run(1, 2, 1, 2, 1'b1, 60, c);        // loop mode, stop in pass 3
    run(10, 20, 5, 8, 1'b0, 15, c);      // stop mid-dwell

    // Reset mid-settle, then start on the first edge after release.
    @(negedge CLK);
    c = cyc;
    step_start = 8'd7; step_end = 8'd200; step_inc = 8'd3; dwell_in = 16'd5; loop = 1'b0;
    start = 1'b1;
    build(c, 7, 200, 3, 5, 1'b0, c + 6);
    foreach (mq[i]) if (mq[i].at <= c + 6) exp_q.push_back(mq[i]);
    @(negedge CLK);
    start = 1'b0;
    while (cyc < c + 6) @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check_outputs_zero("async_reset");
    check("reset_pending_events", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;
    run(7, 9, 1, 3, 1'b0, -1, c);

    for (int r = 0; r < 16; r++) begin
      s0 = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) e0 = int'($urandom_range(0, 255));
      else e0 = (s0 + int'($urandom_range(0, 30)) > 255) ? 255 : s0 + int'($urandom_range(0, 30));
      inc0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      dw0 = int'($urandom_range(0, 6));
      run(s0, e0, inc0, dw0, 1'b0, -1, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
